// File: rtl/psram_responder.sv
// psram_responder: QPI PSRAM target emulating two nibble-wide chips on an
// 8-bit bus, backed by a 2**ADDR_W x 16-bit word array.
// Handles the SPI-mode QPI enable (0x35), quad write (0x38) and quad fast
// read (0xEB). Everything is sampled and driven on the rising edge of i_clk.
//
// Optional feature macro: PSRAM_RESP_QPI_EXIT_EN
//   defined   -> QPI command 0xF5 clears o_qpi_mode
//   undefined -> 0xF5 is an unknown command; only arst_n leaves QPI mode
//
// Handshake: there is no valid/ready pair. A transaction is framed by
// i_psram_csn low; every rising edge with csn low carries exactly one
// command/address nibble pair or data byte, and csn high on any edge aborts
// the transaction and releases the bus on that same edge.
//
// Debug: o_dbg_state exposes the FSM state and o_dbg_oe the bus output
// enable, so checkers can follow the protocol without probing internals.
// ADDR_W must lie in 5..24 (the address shift keeps the low ADDR_W bits).

module psram_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 6
) (
    input  logic        i_clk,
    input  logic        arst_n,
    input  logic        i_psram_csn,
    inout  wire  [7:0]  io_psram_data,
    output logic        o_qpi_mode,
    output logic        o_cmd_err,
    output logic [15:0] o_wr_cnt,
    output logic [3:0]  o_dbg_state,
    output logic        o_dbg_oe
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]        WAIT_L   = WAIT_CYCLES[3:0];
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // ST_IDLE also samples the command high nibble (or first SPI bit) on E0.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_SPI_CMD    = 4'd1,
        ST_CMD_LO     = 4'd2,
        ST_ADDR       = 4'd3,
        ST_READ_WAIT  = 4'd4,
        ST_READ_DATA  = 4'd5,
        ST_WRITE_DATA = 4'd6,
        ST_IGNORE     = 4'd7
    } state_t;

    state_t            state;
    logic [7:0]        io_in;
    logic [3:0]        nib;
    logic              lane_ok;
    logic              spi_ok;
    logic [6:0]        spi_sr;
    logic [2:0]        bit_cnt;
    logic [7:0]        spi_byte;
    logic [3:0]        cmd_hi;
    logic [7:0]        cmd_byte;
    logic              is_rd;
    logic [2:0]        nib_cnt;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] addr_full;
    logic              half;
    logic [7:0]        hi_byte;
    logic [7:0]        lo_hold;
    logic [7:0]        dout;
    logic              oe;

    logic [15:0]       mem [0:DEPTH-1];
    logic [15:0]       rd_word;
    logic              mem_we;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    assign io_psram_data = oe ? dout : 8'hzz;
    assign io_in         = io_psram_data;
    assign nib           = io_in[3:0];
    assign lane_ok       = (io_in[7:4] == io_in[3:0]);
    assign spi_ok        = (io_in[4] == io_in[0]);
    assign spi_byte      = {spi_sr, io_in[0]};
    assign cmd_byte      = {cmd_hi, nib};
    // Address shifts in nibble by nibble; only the low ADDR_W bits survive,
    // which gives the required aliasing of the upper address bits.
    assign addr_full     = {waddr[ADDR_W-5:0], nib};
    assign o_dbg_state   = state;
    assign o_dbg_oe      = oe;

    // Array strobes: write on the lo-byte edge, read on the last address
    // edge (first word) and on every hi-byte edge (prefetch of next word).
    always_comb begin
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        rd_addr = waddr + ADDR_ONE;
        if (!i_psram_csn) begin
            case (state)
                ST_ADDR: begin
                    if (nib_cnt == 3'd5 && lane_ok && is_rd) begin
                        rd_en   = 1'b1;
                        rd_addr = addr_full;
                    end
                end
                ST_READ_WAIT:  rd_en  = (wait_cnt == WAIT_L);
                ST_READ_DATA:  rd_en  = !half;
                ST_WRITE_DATA: mem_we = half;
                default: ;
            endcase
        end
    end

    // Word array with registered read port; contents are never reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[waddr] <= {hi_byte, io_in};
        if (rd_en)  rd_word    <= mem[rd_addr];
    end

    // Protocol FSM with registered outputs and bus drive.
    always_ff @(posedge i_clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            o_qpi_mode <= 1'b0;
            o_cmd_err  <= 1'b0;
            o_wr_cnt   <= 16'd0;
            spi_sr     <= 7'd0;
            bit_cnt    <= 3'd0;
            cmd_hi     <= 4'd0;
            is_rd      <= 1'b0;
            nib_cnt    <= 3'd0;
            wait_cnt   <= 4'd0;
            waddr      <= '0;
            half       <= 1'b0;
            hi_byte    <= 8'd0;
            lo_hold    <= 8'd0;
            dout       <= 8'd0;
            oe         <= 1'b0;
        end else if (i_psram_csn) begin
            // Deselect: drop any half-word and release the bus.
            state <= ST_IDLE;
            oe    <= 1'b0;
            half  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (o_qpi_mode) begin
                        if (!lane_ok) begin
                            o_cmd_err <= 1'b1;
                            state     <= ST_IGNORE;
                        end else begin
                            cmd_hi <= nib;
                            state  <= ST_CMD_LO;
                        end
                    end else if (!spi_ok) begin
                        o_cmd_err <= 1'b1;
                        state     <= ST_IGNORE;
                    end else begin
                        spi_sr  <= {spi_sr[5:0], io_in[0]};
                        bit_cnt <= 3'd1;
                        state   <= ST_SPI_CMD;
                    end
                end
                ST_SPI_CMD: begin
                    if (!spi_ok) begin
                        o_cmd_err <= 1'b1;
                        state     <= ST_IGNORE;
                    end else if (bit_cnt == 3'd7) begin
                        if (spi_byte == 8'h35) o_qpi_mode <= 1'b1;
                        else                   o_cmd_err  <= 1'b1;
                        state <= ST_IGNORE;
                    end else begin
                        spi_sr  <= {spi_sr[5:0], io_in[0]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_CMD_LO: begin
                    nib_cnt <= 3'd0;
                    if (!lane_ok) begin
                        o_cmd_err <= 1'b1;
                        state     <= ST_IGNORE;
                    end else begin
                        case (cmd_byte)
                            8'h38: begin
                                is_rd <= 1'b0;
                                state <= ST_ADDR;
                            end
                            8'hEB: begin
                                is_rd <= 1'b1;
                                state <= ST_ADDR;
                            end
`ifdef PSRAM_RESP_QPI_EXIT_EN
                            8'hF5: begin
                                o_qpi_mode <= 1'b0;
                                state      <= ST_IGNORE;
                            end
`endif
                            default: begin
                                o_cmd_err <= 1'b1;
                                state     <= ST_IGNORE;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (!lane_ok) begin
                        o_cmd_err <= 1'b1;
                        state     <= ST_IGNORE;
                    end else begin
                        waddr <= addr_full;
                        if (nib_cnt == 3'd5) begin
                            half <= 1'b0;
                            if (is_rd) begin
                                wait_cnt <= 4'd1;
                                state    <= ST_READ_WAIT;
                            end else begin
                                state <= ST_WRITE_DATA;
                            end
                        end else begin
                            nib_cnt <= nib_cnt + 3'd1;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    // The last dummy edge already launches the hi byte.
                    if (wait_cnt == WAIT_L) begin
                        dout    <= rd_word[15:8];
                        lo_hold <= rd_word[7:0];
                        oe      <= 1'b1;
                        half    <= 1'b1;
                        state   <= ST_READ_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_READ_DATA: begin
                    // lo_hold keeps the lo byte while rd_word is refilled.
                    if (half) begin
                        dout  <= lo_hold;
                        half  <= 1'b0;
                        waddr <= waddr + ADDR_ONE;
                    end else begin
                        dout    <= rd_word[15:8];
                        lo_hold <= rd_word[7:0];
                        half    <= 1'b1;
                    end
                end
                ST_WRITE_DATA: begin
                    if (!half) begin
                        hi_byte <= io_in;
                        half    <= 1'b1;
                    end else begin
                        half     <= 1'b0;
                        o_wr_cnt <= o_wr_cnt + 16'd1;
                        waddr    <= waddr + ADDR_ONE;
                    end
                end
                ST_IGNORE: ;
                default: state <= ST_IGNORE;
            endcase
        end
    end

endmodule
